// File: rtl/timed_ram_pkg.sv
// Shared types and limits for timed_ram: channel-id width helper, pipeline stage record,
// and the NCH/LAT range constants.
package timed_ram_pkg;

  localparam int unsigned NCH_MIN = 1;
  localparam int unsigned NCH_MAX = 8;
  localparam int unsigned LAT_MIN = 1;
  localparam int unsigned LAT_MAX = 16;

  // Stage fields are sized for the largest configuration; unused upper bits stay zero.
  localparam int unsigned CHW_MAX = 3;
  localparam int unsigned DW_MAX  = 256;

  function automatic int unsigned ch_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic               valid;
    logic [CHW_MAX-1:0] ch;
    logic [DW_MAX-1:0]  data;
  } pipe_stage_t;

endpackage

// File: rtl/timed_ram_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from the request vector starting at the priority
// pointer; the pointer moves past the granted channel whenever a grant is issued.
module rr_arbiter
  import timed_ram_pkg::*;
#(
  parameter int unsigned NCH = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NCH-1:0]            i_req,
  output logic [NCH-1:0]            o_grant,
  output logic [ch_width(NCH)-1:0]  o_grant_id
);

  localparam int unsigned CHW = ch_width(NCH);

  logic [CHW-1:0] r_ptr;
  logic           w_found;

  // Scan channels in priority order ptr, ptr+1, ...; constant indices keep the search flat.
  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    w_found    = 1'b0;
    if (!i_rst) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        for (int unsigned i = 0; i < NCH; i++) begin
          if (!w_found && i_req[i] && (i == ((int'(r_ptr) + k) % NCH))) begin
            o_grant[i] = 1'b1;
            o_grant_id = CHW'(i);
            w_found    = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (o_grant_id == CHW'(NCH - 1)) ? '0 : o_grant_id + CHW'(1);
    end
  end

endmodule

// File: rtl/timed_ram.sv
// Multi-channel read RAM with round-robin acceptance and fixed LAT-cycle response pipeline.
// Optional statistics outputs are enabled by defining TIMED_RAM_STATS_EN.
module timed_ram
  import timed_ram_pkg::*;
#(
  parameter int unsigned NCH   = 2,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned LAT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       global_clock,
  input  logic [NCH-1:0]    req_valid,
  input  logic [NCH*AW-1:0] req_addr,
  output logic [NCH-1:0]    req_ready,
  output logic [NCH-1:0]    rsp_valid,
  output logic [NCH*DW-1:0] rsp_data,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data
`ifdef TIMED_RAM_STATS_EN
  ,
  output logic [NCH*32-1:0] stat_accepts,
  output logic [63:0]       stat_last_ts
`endif
);

  localparam int unsigned IW  = $clog2(DEPTH);
  localparam int unsigned CHW = ch_width(NCH);

  logic [NCH-1:0]  w_grant;
  logic [CHW-1:0]  w_gid;
  logic            w_accept;
  logic [IW-1:0]   w_rd_idx;
  logic [IW-1:0]   w_wr_idx;
  logic [DW-1:0]   w_rd_data;
  pipe_stage_t     w_stage_in;
  logic            w_unused;

  logic [DW-1:0]   r_mem [DEPTH];
  pipe_stage_t     r_pipe [LAT];

  rr_arbiter #(.NCH(NCH)) u_arb (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req_valid),
    .o_grant    (w_grant),
    .o_grant_id (w_gid)
  );

  assign req_ready = w_grant;
  assign w_accept  = |(req_valid & w_grant);

  always_comb begin
    w_rd_idx = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (w_grant[i]) w_rd_idx = req_addr[i*AW + 2 +: IW];
    end
  end

  assign w_wr_idx  = wr_addr[2 +: IW];
  assign w_rd_data = r_mem[w_rd_idx];

  // Read is sampled combinationally before the edge, so a same-cycle write yields old data.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) r_mem[w_wr_idx] <= wr_data;
  end

  always_comb begin
    w_stage_in              = '0;
    w_stage_in.valid        = w_accept;
    w_stage_in.ch           = CHW_MAX'(w_gid);
    w_stage_in.data[DW-1:0] = w_rd_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_stage_in;
      for (int unsigned i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (r_pipe[LAT-1].valid && (r_pipe[LAT-1].ch == CHW_MAX'(i))) begin
        rsp_valid[i]         = 1'b1;
        rsp_data[i*DW +: DW] = r_pipe[LAT-1].data[DW-1:0];
      end
    end
  end

`ifdef TIMED_RAM_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_accepts <= '0;
      stat_last_ts <= '0;
    end else if (w_accept) begin
      stat_last_ts <= global_clock;
      for (int unsigned i = 0; i < NCH; i++) begin
        if (w_grant[i] && (stat_accepts[i*32 +: 32] != '1))
          stat_accepts[i*32 +: 32] <= stat_accepts[i*32 +: 32] + 32'd1;
      end
    end
  end
`endif

  // Address bits above the word index and unused stage padding are intentionally ignored.
  assign w_unused = ^{global_clock, req_addr, wr_addr, r_pipe[LAT-1]};

endmodule
